// File: rtl/servant_pm_pkg.sv
// Shared state encodings for the servant sleep/wake power-management controller.
package servant_pm_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SLEEP = 2'd2;
  localparam logic [1:0] ST_WAKE  = 2'd3;

  typedef enum logic [1:0] {
    PM_RUN   = ST_RUN,
    PM_DRAIN = ST_DRAIN,
    PM_SLEEP = ST_SLEEP,
    PM_WAKE  = ST_WAKE
  } pm_state_t;

endpackage

// File: rtl/servant_pm_sync.sv
// Multi-bit, multi-stage flop synchroniser for the asynchronous wake sources.
module servant_pm_sync
  import servant_pm_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/servant_pm_ctrl.sv
// Sleep/wake clock-enable controller: gates non-kept channels on a sleep request once idle.
// Define SERVANT_PM_TIMER_EN to add the self-wake timer loaded from i_timer_load.
module servant_pm_ctrl
  import servant_pm_pkg::*;
#(
  parameter int              N_CH          = 2,
  parameter int              N_IRQ         = 1,
  parameter logic [N_CH-1:0] CH_KEEP       = 2'b10,
  parameter int              SYNC_STAGES   = 2,
  parameter int              SETTLE_CYCLES = 4,
  parameter int              TIMER_W       = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_sleep_req,
  input  logic               i_idle,
  input  logic [N_IRQ-1:0]   i_irq,
  input  logic [N_IRQ-1:0]   i_irq_mask,
  input  logic [TIMER_W-1:0] i_timer_load,
  output logic [N_CH-1:0]    o_clk_en,
  output logic               o_sleeping,
  output logic               o_wake_ack,
  output logic [N_IRQ-1:0]   o_wake_src,
  output logic               o_timer_wake
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] settle_cnt;
  logic [N_IRQ-1:0] irq_sync;
  logic [N_IRQ-1:0] irq_s;
  logic             wake;
  logic             timer_fire;

  servant_pm_sync #(
    .WIDTH  (N_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_irq),
    .o_q     (irq_sync)
  );

  // Masking after the synchroniser keeps mask changes glitch-free; the extra flop sets wake latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_s <= '0;
    end else begin
      irq_s <= irq_sync & i_irq_mask;
    end
  end

  assign wake = |irq_s;

`ifdef SERVANT_PM_TIMER_EN
  logic [TIMER_W-1:0] timer_cnt;
  logic               enter_sleep;

  assign enter_sleep = (state == ST_DRAIN) && !wake && i_idle;
  // A zero load never reaches the fire value of 1, so it leaves the timer disabled.
  assign timer_fire  = (state == ST_SLEEP) && (timer_cnt == TIMER_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer_cnt <= '0;
    end else if (enter_sleep) begin
      timer_cnt <= i_timer_load;
    end else if ((state == ST_SLEEP) && (timer_cnt != '0)) begin
      timer_cnt <= timer_cnt - TIMER_W'(1);
    end else if (state != ST_SLEEP) begin
      timer_cnt <= '0;
    end
  end
`else
  logic unused_timer_load;

  assign unused_timer_load = ^i_timer_load;
  assign timer_fire        = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_RUN;
      o_clk_en     <= '1;
      o_sleeping   <= 1'b0;
      o_wake_ack   <= 1'b0;
      o_wake_src   <= '0;
      o_timer_wake <= 1'b0;
      settle_cnt   <= '0;
    end else begin
      o_wake_ack   <= 1'b0;
      o_timer_wake <= 1'b0;
      case (state)
        ST_RUN: begin
          o_clk_en <= '1;
          if (i_sleep_req) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (wake) begin
            state      <= ST_RUN;
            o_wake_ack <= 1'b1;
            o_wake_src <= irq_s;
          end else if (i_idle) begin
            state      <= ST_SLEEP;
            o_clk_en   <= CH_KEEP;
            o_sleeping <= 1'b1;
          end
        end
        ST_SLEEP: begin
          if (wake || timer_fire) begin
            state        <= ST_WAKE;
            o_wake_src   <= irq_s;
            o_clk_en     <= '1;
            o_timer_wake <= timer_fire;
            settle_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
          end
        end
        ST_WAKE: begin
          if (settle_cnt == '0) begin
            state      <= ST_RUN;
            o_sleeping <= 1'b0;
            o_wake_ack <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servant_pm_ctrl.sv
// Directed bench for servant_pm_ctrl: expectations are queued with a due cycle and checked when it arrives.
module tb_servant_pm_ctrl;

  localparam int N_CH    = 2;
  localparam int N_IRQ   = 2;
  localparam int TIMER_W = 16;

  localparam int F_CLKEN = 0;
  localparam int F_SLEEP = 1;
  localparam int F_ACK   = 2;
  localparam int F_SRC   = 3;
  localparam int F_TWAKE = 4;

  typedef struct {
    int         at;
    string      tag;
    int         field;
    logic [1:0] value;
  } exp_t;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic               i_sleep_req;
  logic               i_idle;
  logic [N_IRQ-1:0]   i_irq;
  logic [N_IRQ-1:0]   i_irq_mask;
  logic [TIMER_W-1:0] i_timer_load;
  logic [N_CH-1:0]    o_clk_en;
  logic               o_sleeping;
  logic               o_wake_ack;
  logic [N_IRQ-1:0]   o_wake_src;
  logic               o_timer_wake;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];

  servant_pm_ctrl #(
    .N_CH          (N_CH),
    .N_IRQ         (N_IRQ),
    .CH_KEEP       (2'b10),
    .SYNC_STAGES   (2),
    .SETTLE_CYCLES (4),
    .TIMER_W       (TIMER_W)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_sleep_req  (i_sleep_req),
    .i_idle       (i_idle),
    .i_irq        (i_irq),
    .i_irq_mask   (i_irq_mask),
    .i_timer_load (i_timer_load),
    .o_clk_en     (o_clk_en),
    .o_sleeping   (o_sleeping),
    .o_wake_ack   (o_wake_ack),
    .o_wake_src   (o_wake_src),
    .o_timer_wake (o_timer_wake)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [1:0] sample(input int field);
    case (field)
      F_CLKEN: return o_clk_en;
      F_SLEEP: return {1'b0, o_sleeping};
      F_ACK:   return {1'b0, o_wake_ack};
      F_SRC:   return o_wake_src;
      F_TWAKE: return {1'b0, o_timer_wake};
      default: return 2'bxx;
    endcase
  endfunction

  task automatic checkValue(input string tag, input logic [1:0] observed, input logic [1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %b expected %b at cycle %0d", tag, observed, expected, cyc);
    end
  endtask

  task automatic expectAt(input int delay, input string tag, input int field, input logic [1:0] value);
    exp_t e;
    e.at    = cyc + delay;
    e.tag   = tag;
    e.field = field;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        checkValue(sb[i].tag, sample(sb[i].field), sb[i].value);
        sb.delete(i);
      end
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic applyStimulus(input logic sleep_req, input logic idle, input logic [1:0] irq,
                               input logic [1:0] mask);
    i_sleep_req = sleep_req;
    i_idle      = idle;
    i_irq       = irq;
    i_irq_mask  = mask;
  endtask

  // Irq raised now is sampled next edge; clocks return 3 edges after that, ack 4 edges later still.
  task automatic irqWake(input string tag, input logic [1:0] irq, input logic [1:0] mask,
                         input logic [1:0] src);
    applyStimulus(1'b0, 1'b1, irq, mask);
    expectAt(3, {tag, "_still_gated"}, F_CLKEN, 2'b10);
    expectAt(4, {tag, "_clk_en"}, F_CLKEN, 2'b11);
    expectAt(4, {tag, "_src"}, F_SRC, src);
    expectAt(7, {tag, "_settling"}, F_SLEEP, 2'b01);
    expectAt(7, {tag, "_no_early_ack"}, F_ACK, 2'b00);
    expectAt(8, {tag, "_ack"}, F_ACK, 2'b01);
    expectAt(8, {tag, "_awake"}, F_SLEEP, 2'b00);
    expectAt(9, {tag, "_ack_one_cycle"}, F_ACK, 2'b00);
    idleCycles(9);
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b01);
    idleCycles(5);
  endtask

  task automatic enterSleep(input string tag);
    applyStimulus(1'b1, 1'b1, 2'b00, 2'b01);
    expectAt(1, {tag, "_drain_clk_en"}, F_CLKEN, 2'b11);
    expectAt(2, {tag, "_sleep_clk_en"}, F_CLKEN, 2'b10);
    expectAt(2, {tag, "_sleep_flag"}, F_SLEEP, 2'b01);
    tick();
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b01);
    tick();
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_timer_load = '0;
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b01);
    idleCycles(2);
    checkValue("reset_clk_en", o_clk_en, 2'b11);
    checkValue("reset_sleeping", {1'b0, o_sleeping}, 2'b00);
    checkValue("reset_ack", {1'b0, o_wake_ack}, 2'b00);
    checkValue("reset_src", o_wake_src, 2'b00);
    checkValue("reset_timer_wake", {1'b0, o_timer_wake}, 2'b00);
    i_rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] normal sleep and irq0 wake");
    enterSleep("normal");
    idleCycles(3);
    irqWake("normal_wake", 2'b01, 2'b01, 2'b01);

    $display("[TB] drain holds while bus busy");
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b01);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b01);
    for (int k = 0; k < 10; k++) begin
      expectAt(1, "drain_hold_clk_en", F_CLKEN, 2'b11);
      expectAt(1, "drain_hold_awake", F_SLEEP, 2'b00);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b01);
    expectAt(1, "drain_release_clk_en", F_CLKEN, 2'b10);
    tick();
    tick();
    irqWake("drain_wake", 2'b01, 2'b01, 2'b01);

    $display("[TB] abort with irq pending");
    applyStimulus(1'b0, 1'b1, 2'b10, 2'b11);
    idleCycles(4);
    applyStimulus(1'b1, 1'b1, 2'b10, 2'b11);
    expectAt(1, "abort_drain_clk_en", F_CLKEN, 2'b11);
    expectAt(1, "abort_drain_no_ack", F_ACK, 2'b00);
    expectAt(2, "abort_clk_en", F_CLKEN, 2'b11);
    expectAt(2, "abort_ack", F_ACK, 2'b01);
    expectAt(2, "abort_src", F_SRC, 2'b10);
    expectAt(2, "abort_awake", F_SLEEP, 2'b00);
    expectAt(3, "abort_stays_run", F_CLKEN, 2'b11);
    expectAt(3, "abort_ack_one_cycle", F_ACK, 2'b00);
    tick();
    applyStimulus(1'b0, 1'b1, 2'b10, 2'b11);
    idleCycles(3);
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b01);
    idleCycles(5);

    $display("[TB] masked source ignored");
    enterSleep("mask");
    applyStimulus(1'b0, 1'b1, 2'b10, 2'b01);
    expectAt(10, "masked_asleep_10", F_CLKEN, 2'b10);
    expectAt(30, "masked_asleep_30", F_CLKEN, 2'b10);
    expectAt(50, "masked_asleep_50", F_CLKEN, 2'b10);
    expectAt(50, "masked_sleep_flag", F_SLEEP, 2'b01);
    idleCycles(50);
    irqWake("unmasked_wake", 2'b11, 2'b01, 2'b01);

`ifdef SERVANT_PM_TIMER_EN
    $display("[TB] timer wake");
    i_timer_load = 16'd5;
    applyStimulus(1'b1, 1'b1, 2'b00, 2'b01);
    expectAt(2, "timer_sleep_clk_en", F_CLKEN, 2'b10);
    expectAt(6, "timer_not_yet", F_CLKEN, 2'b10);
    expectAt(6, "timer_no_early_pulse", F_TWAKE, 2'b00);
    expectAt(7, "timer_wake_pulse", F_TWAKE, 2'b01);
    expectAt(7, "timer_wake_clk_en", F_CLKEN, 2'b11);
    expectAt(7, "timer_wake_src", F_SRC, 2'b00);
    expectAt(8, "timer_pulse_one_cycle", F_TWAKE, 2'b00);
    expectAt(10, "timer_no_early_ack", F_ACK, 2'b00);
    expectAt(11, "timer_wake_ack", F_ACK, 2'b01);
    tick();
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b01);
    idleCycles(11);

    $display("[TB] zero timer load disables timer");
    i_timer_load = 16'd0;
    enterSleep("timer_zero");
    expectAt(40, "timer_zero_asleep", F_CLKEN, 2'b10);
    expectAt(40, "timer_zero_no_pulse", F_TWAKE, 2'b00);
    idleCycles(40);
`else
    $display("[TB] timer load ignored without timer");
    i_timer_load = 16'd5;
    enterSleep("no_timer");
    expectAt(5, "no_timer_asleep", F_CLKEN, 2'b10);
    expectAt(5, "no_timer_pulse", F_TWAKE, 2'b00);
    expectAt(20, "no_timer_still_asleep", F_CLKEN, 2'b10);
    idleCycles(20);
`endif
    irqWake("post_timer_wake", 2'b01, 2'b01, 2'b01);

    $display("[TB] async reset during sleep");
    i_timer_load = '0;
    enterSleep("reset");
    idleCycles(3);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkValue("async_reset_clk_en", o_clk_en, 2'b11);
    checkValue("async_reset_awake", {1'b0, o_sleeping}, 2'b00);
    tick();
    i_rst_n = 1'b1;
    tick();
    checkValue("post_reset_src", o_wake_src, 2'b00);
    checkValue("post_reset_clk_en", o_clk_en, 2'b11);
    enterSleep("post_reset");
    irqWake("post_reset_wake", 2'b01, 2'b01, 2'b01);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_drained: observed %0d pending expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
